// File: rtl/dircc_procmem_pkg.sv
// Shared types and elaboration helpers for the DiRCC processing-node dual-port memory.
package dircc_procmem_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clear_state_e;

  // Returns at least 1 so a degenerate depth still yields a legal vector width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int lane_groups(input int a_data_w, input int b_data_w);
    return a_data_w / b_data_w;
  endfunction

endpackage

// File: rtl/dircc_processing_mem_dp_if.sv
// Avalon-MM slave port bundle used for both sides of the processing-node memory.
interface dircc_processing_mem_dp_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/dircc_procmem_rd_pipe.sv
// Read-return pipeline: LATENCY valid/data stages that hold while freeze is high.
module dircc_procmem_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];

  // The output stage drops its valid on a frozen edge so a beat is never presented twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else if (freeze) begin
      vld_q[LATENCY-1] <= 1'b0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/dircc_processing_mem_dp.sv
// Mixed-width true dual-port node memory with Avalon handshakes and a zero-fill engine.
// Optional DIRCC_PROCMEM_COLLISION_EN adds collision_flag / collision_count outputs.
//
//   state     | meaning
//   CLR_IDLE  | normal access; clear_req starts a fill
//   CLR_CLEAR | writing zero to word cnt_q each unfrozen cycle, both ports stalled
//   CLR_DONE  | fill finished, clear_done pulses for one cycle
module dircc_processing_mem_dp
  import dircc_procmem_pkg::*;
#(
  parameter int    A_DATA_W     = 32,
  parameter int    B_DATA_W     = 16,
  parameter int    A_DEPTH      = 10240,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        reset_req,
  dircc_processing_mem_dp_if.slave    s1,
  dircc_processing_mem_dp_if.slave    s2,
  input  logic                        clear_req,
  output logic                        clear_busy,
  output logic                        clear_done
`ifdef DIRCC_PROCMEM_COLLISION_EN
  ,
  output logic                        collision_flag,
  output logic [15:0]                 collision_count
`endif
);

  localparam int R       = lane_groups(A_DATA_W, B_DATA_W);
  localparam int B_DEPTH = A_DEPTH * R;
  localparam int A_AW    = clog2(A_DEPTH);
  localparam int B_AW    = clog2(B_DEPTH);
  localparam int A_BE    = A_DATA_W / 8;
  localparam int B_BE    = B_DATA_W / 8;
  localparam int LANE_W  = clog2(R);
  localparam logic [B_AW-1:0] R_B = B_AW'(R);

  // Contents are not reset; INIT_FILE preloading is left to the device RAM flow.
  logic [A_DATA_W-1:0] mem [A_DEPTH];

  clear_state_e        state_q;
  logic [A_AW-1:0]     cnt_q;
  logic                wait_req;
  logic                s1_rd_acc, s1_wr_acc, s2_rd_acc, s2_wr_acc;
  logic [A_AW-1:0]     s2_word;
  logic [LANE_W-1:0]   s2_lane;
  logic [A_BE-1:0]     wb_be;
  logic [A_DATA_W-1:0] wb_data;
  logic                wa_en;
  logic [A_AW-1:0]     wa_addr;
  logic [A_BE-1:0]     wa_be;
  logic [A_DATA_W-1:0] wa_data;
  logic [A_DATA_W-1:0] s1_merged, s2_merged;
  logic [B_DATA_W-1:0] s2_rd_word;

  assign wait_req       = reset_req | clear_busy;
  assign s1.waitrequest = wait_req;
  assign s2.waitrequest = wait_req;

  // A combined read+write is treated as a write only.
  assign s1_wr_acc = s1.write & ~wait_req;
  assign s1_rd_acc = s1.read & ~s1.write & ~wait_req;
  assign s2_wr_acc = s2.write & ~wait_req;
  assign s2_rd_acc = s2.read & ~s2.write & ~wait_req;

  assign s2_word = A_AW'(s2.address / R_B);
  assign s2_lane = LANE_W'(s2.address % R_B);
  assign wb_be   = A_BE'(s2.byteenable) << (s2_lane * B_BE);
  assign wb_data = A_DATA_W'(s2.writedata) << (s2_lane * B_DATA_W);

  // s1 merges on top of s2's result for a shared word, so s1 wins only on overlapping bytes.
  always_comb begin
    wa_en   = s1_wr_acc;
    wa_addr = s1.address;
    wa_be   = s1.byteenable;
    wa_data = s1.writedata;
    if (state_q == CLR_CLEAR && !reset_req) begin
      wa_en   = 1'b1;
      wa_addr = cnt_q;
      wa_be   = '1;
      wa_data = '0;
    end
    s2_merged = mem[s2_word];
    for (int b = 0; b < A_BE; b++)
      if (wb_be[b]) s2_merged[8*b +: 8] = wb_data[8*b +: 8];
    s1_merged = (s2_wr_acc && s2_word == wa_addr) ? s2_merged : mem[wa_addr];
    for (int b = 0; b < A_BE; b++)
      if (wa_be[b]) s1_merged[8*b +: 8] = wa_data[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (s2_wr_acc) mem[s2_word] <= s2_merged;
    if (wa_en)     mem[wa_addr] <= s1_merged;
  end

  assign s2_rd_word = mem[s2_word][s2_lane*B_DATA_W +: B_DATA_W];

  dircc_procmem_rd_pipe #(.LATENCY(READ_LATENCY), .DATA_W(A_DATA_W)) u_rd_pipe_s1 (
    .clk       (clk),
    .rst_n     (reset_n),
    .freeze    (reset_req),
    .in_valid  (s1_rd_acc),
    .in_data   (mem[s1.address]),
    .out_valid (s1.readdatavalid),
    .out_data  (s1.readdata)
  );

  dircc_procmem_rd_pipe #(.LATENCY(READ_LATENCY), .DATA_W(B_DATA_W)) u_rd_pipe_s2 (
    .clk       (clk),
    .rst_n     (reset_n),
    .freeze    (reset_req),
    .in_valid  (s2_rd_acc),
    .in_data   (s2_rd_word),
    .out_valid (s2.readdatavalid),
    .out_data  (s2.readdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLR_IDLE;
      cnt_q      <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (!reset_req) begin
        case (state_q)
          CLR_IDLE: begin
            if (clear_req) begin
              state_q    <= CLR_CLEAR;
              cnt_q      <= '0;
              clear_busy <= 1'b1;
            end
          end
          CLR_CLEAR: begin
            if (cnt_q == A_AW'(A_DEPTH - 1)) begin
              state_q    <= CLR_DONE;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          CLR_DONE: state_q <= CLR_IDLE;
          default:  state_q <= CLR_IDLE;
        endcase
      end
    end
  end

`ifdef DIRCC_PROCMEM_COLLISION_EN
  logic collide;
  assign collide = s1_wr_acc & s2_wr_acc & (s1.address == s2_word) & (|(s1.byteenable & wb_be));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision_flag  <= 1'b0;
      collision_count <= '0;
    end else begin
      if (collide)         collision_flag <= 1'b1;
      else if (clear_done) collision_flag <= 1'b0;
      if (collide && collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dircc_processing_mem_dp.sv
// Scoreboard bench for dircc_processing_mem_dp: directed vectors, monitor-side read checking.
module tb_dircc_processing_mem_dp;
  import dircc_procmem_pkg::*;

  localparam int A_DEPTH = 64;
  localparam int RL      = 2;
  localparam int A_AW    = 6;
  localparam int B_AW    = 7;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_req = 1'b0;
  logic clear_req = 1'b0;
  logic clear_busy, clear_done;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t s1_q[$];
  exp_t s2_q[$];
  exp_t e1, e2;
  int   busy_cnt, done_cnt;

  dircc_processing_mem_dp_if #(.ADDR_W(A_AW), .DATA_W(32)) s1_if ();
  dircc_processing_mem_dp_if #(.ADDR_W(B_AW), .DATA_W(16)) s2_if ();

`ifdef DIRCC_PROCMEM_COLLISION_EN
  logic        collision_flag;
  logic [15:0] collision_count;
`endif

  dircc_processing_mem_dp #(
    .A_DATA_W(32), .B_DATA_W(16), .A_DEPTH(A_DEPTH), .READ_LATENCY(RL), .INIT_FILE("")
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reset_req  (reset_req),
    .s1         (s1_if),
    .s2         (s2_if),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
`ifdef DIRCC_PROCMEM_COLLISION_EN
    ,
    .collision_flag  (collision_flag),
    .collision_count (collision_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every readdatavalid beat must match the oldest expectation, data and cycle.
  always @(negedge clk) begin
    if (s1_if.readdatavalid) begin
      checks++;
      if (s1_q.size() == 0) begin
        errors++;
        $display("FAIL s1_unexpected_rdv got %h at cycle %0d expected no beat", s1_if.readdata, cyc);
      end else begin
        e1 = s1_q.pop_front();
        if (s1_if.readdata !== e1.data || cyc != e1.cyc) begin
          errors++;
          $display("FAIL s1_read got %h at cycle %0d expected %h at cycle %0d",
                   s1_if.readdata, cyc, e1.data, e1.cyc);
        end
      end
    end
    if (s2_if.readdatavalid) begin
      checks++;
      if (s2_q.size() == 0) begin
        errors++;
        $display("FAIL s2_unexpected_rdv got %h at cycle %0d expected no beat", s2_if.readdata, cyc);
      end else begin
        e2 = s2_q.pop_front();
        if ({16'h0, s2_if.readdata} !== e2.data || cyc != e2.cyc) begin
          errors++;
          $display("FAIL s2_read got %h at cycle %0d expected %h at cycle %0d",
                   s2_if.readdata, cyc, e2.data, e2.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s1_cmd(input bit rd, input bit wr, input logic [A_AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    s1_if.read = rd; s1_if.write = wr; s1_if.address = a;
    s1_if.writedata = d; s1_if.byteenable = be;
  endtask

  task automatic s2_cmd(input bit rd, input bit wr, input logic [B_AW-1:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    s2_if.read = rd; s2_if.write = wr; s2_if.address = a;
    s2_if.writedata = d; s2_if.byteenable = be;
  endtask

  task automatic bus_idle();
    s1_cmd(1'b0, 1'b0, '0, '0, '0);
    s2_cmd(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic exp1(input logic [31:0] d, input int extra);
    exp_t e;
    e.data = d; e.cyc = cyc + RL + extra;
    s1_q.push_back(e);
  endtask

  task automatic exp2(input logic [15:0] d, input int extra);
    exp_t e;
    e.data = {16'h0, d}; e.cyc = cyc + RL + extra;
    s2_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s1_rdv", s1_if.readdatavalid, 0);
    check("rst_s1_rdata", s1_if.readdata, 0);
    check("rst_s2_rdv", s2_if.readdatavalid, 0);
    check("rst_s2_rdata", s2_if.readdata, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_s1_wait", s1_if.waitrequest, 0);
    reset_n = 1'b1;
    tick();

    // s1 writes, s2 reads both lane groups back to back
    s1_cmd(0, 1, 5, 32'hDEADBEEF, 4'hF); tick();
    bus_idle(); s2_cmd(1, 0, 10, 0, 2'b11); exp2(16'hBEEF, 0); tick();
    s2_cmd(1, 0, 11, 0, 2'b11); exp2(16'hDEAD, 0);
    s1_cmd(1, 0, 5, 0, 4'hF); exp1(32'hDEADBEEF, 0); tick();
    bus_idle(); repeat (4) tick();
    check("s2_rdata_hold", s2_if.readdata, 32'h0000DEAD);

    // s2 byte write lands in byte 2 of s1 word 1
    s1_cmd(0, 1, 1, 32'h11223344, 4'hF); tick();
    bus_idle(); s2_cmd(0, 1, 3, 16'h1234, 2'b01); tick();
    bus_idle(); s1_cmd(1, 0, 1, 0, 0); exp1(32'h11343344, 0); tick();
    bus_idle(); s2_cmd(1, 0, 2, 0, 0); exp2(16'h3344, 0); tick();
    s2_cmd(1, 0, 3, 0, 0); exp2(16'h1134, 0); tick();
    bus_idle();

    // simultaneous writes: full overlap, no overlap, partial overlap
    s1_cmd(0, 1, 0, 32'hAAAAAAAA, 4'hF); s2_cmd(0, 1, 0, 16'h5555, 2'b11); tick();
    s1_cmd(0, 1, 2, 32'h99887766, 4'b1100); s2_cmd(0, 1, 4, 16'hABCD, 2'b11); tick();
    bus_idle(); s1_cmd(0, 1, 3, 32'h0, 4'hF); tick();
    s1_cmd(0, 1, 3, 32'h000000EE, 4'b0001); s2_cmd(0, 1, 6, 16'h7788, 2'b11); tick();
    bus_idle(); s1_cmd(1, 0, 0, 0, 0); exp1(32'hAAAAAAAA, 0);
    s2_cmd(1, 0, 1, 0, 0); exp2(16'hAAAA, 0); tick();
    bus_idle(); s1_cmd(1, 0, 2, 0, 0); exp1(32'h9988ABCD, 0); tick();
    s1_cmd(1, 0, 3, 0, 0); exp1(32'h000077EE, 0); tick();
    bus_idle();
`ifdef DIRCC_PROCMEM_COLLISION_EN
    check("coll_flag_set", collision_flag, 1);
    check("coll_count", collision_count, 2);
`endif

    // mixed-port read-during-write returns old data
    s1_cmd(0, 1, 7, 32'hCAFEF00D, 4'hF); tick();
    s1_cmd(1, 0, 7, 0, 0); s2_cmd(0, 1, 14, 16'h1111, 2'b11); exp1(32'hCAFEF00D, 0); tick();
    bus_idle(); s1_cmd(1, 0, 7, 0, 0); exp1(32'hCAFE1111, 0); tick();
    s1_cmd(0, 1, 7, 32'h22220000, 4'b1100); s2_cmd(1, 0, 15, 0, 0); exp2(16'hCAFE, 0); tick();
    bus_idle(); s2_cmd(1, 0, 15, 0, 0); exp2(16'h2222, 0); tick();
    // read together with write: write only, no beat
    bus_idle(); s1_cmd(1, 1, 8, 32'h0BADCAFE, 4'hF); tick();
    s1_cmd(1, 0, 8, 0, 0); exp1(32'h0BADCAFE, 0); tick();
    bus_idle(); repeat (4) tick();

    // freeze for three edges while a read is in flight
    s1_cmd(1, 0, 5, 0, 0); exp1(32'hDEADBEEF, 3); tick();
    bus_idle(); reset_req = 1'b1; s2_cmd(1, 0, 10, 0, 0); tick();
    check("frz_s1_wait", s1_if.waitrequest, 1);
    check("frz_s2_wait", s2_if.waitrequest, 1);
    tick(); tick();
    bus_idle(); reset_req = 1'b0;
    repeat (5) tick();

    // zero-fill; a read accepted on the entry edge still sees old data
    s1_cmd(1, 0, 5, 0, 0); exp1(32'hDEADBEEF, 0); clear_req = 1'b1; tick();
    bus_idle();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < A_DEPTH + 8; i++) begin
      @(negedge clk);
      if (i == 2) clear_req = 1'b0;
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
      if (i == 0) begin
        check("clr_s1_wait", s1_if.waitrequest, 1);
        check("clr_s2_wait", s2_if.waitrequest, 1);
      end
    end
    check("clr_busy_cycles", busy_cnt, A_DEPTH);
    check("clr_done_pulses", done_cnt, 1);
`ifdef DIRCC_PROCMEM_COLLISION_EN
    check("coll_flag_cleared", collision_flag, 0);
`endif
    tick();
    for (int w = 0; w < A_DEPTH; w++) begin
      s1_cmd(1, 0, A_AW'(w), 0, 0); exp1(32'h0, 0);
      if (w == A_DEPTH - 1) begin
        s2_cmd(1, 0, 7'd127, 0, 0); exp2(16'h0, 0);
      end
      tick();
    end
    bus_idle(); repeat (5) tick();

    // async reset in the middle of a fill
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (10) tick();
    check("mid_clr_busy", clear_busy, 1);
    #2; reset_n = 1'b0; #1;
    check("async_rst_busy", clear_busy, 0);
    check("async_rst_done", clear_done, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", clear_busy, 0);
    check("post_rst_wait", s1_if.waitrequest, 0);
`ifdef DIRCC_PROCMEM_COLLISION_EN
    check("post_rst_coll_count", collision_count, 0);
`endif
    repeat (3) tick();
    check("s1_q_drained", s1_q.size(), 0);
    check("s2_q_drained", s2_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dircc_processing_mem_dp.md
Name: dircc_processing_mem_dp

Overview:
Parametrised mixed-width true dual-port on-chip memory for a DiRCC processing node. Port s1 serves the Nios data master; port s2 serves the narrower mailbox/DMA side. Compared with the fixed per-node memories, it adds configurable widths, depth and read latency, Avalon readdatavalid/waitrequest handshakes, and a hardware zero-fill (clear) engine. One instance per node replaces the per-node generated memory files.

Parameters:
A_DATA_W, 32, s1 data width in bits; multiple of 8 and of B_DATA_W
B_DATA_W, 16, s2 data width in bits; multiple of 8
A_DEPTH, 10240, s1 word count; B_DEPTH = A_DEPTH*A_DATA_W/B_DATA_W (derived)
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2
INIT_FILE, "", hex initialisation file; empty means contents are undefined at configuration

Ports:
clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
reset_req  in  1  freeze request; high acts as a global clock-enable-low
s1_address  in  clog2(A_DEPTH)  s1 word address
s1_byteenable  in  A_DATA_W/8  s1 byte lanes
s1_read, s1_write  in  1  s1 command
s1_writedata  in  A_DATA_W  s1 write data
s1_readdata  out  A_DATA_W  s1 read data
s1_readdatavalid  out  1  s1 read data valid
s1_waitrequest  out  1  s1 stall
s2_address  in  clog2(B_DEPTH)  s2 word address
s2_byteenable  in  B_DATA_W/8  s2 byte lanes
s2_read, s2_write  in  1  s2 command
s2_writedata  in  B_DATA_W  s2 write data
s2_readdata  out  B_DATA_W  s2 read data
s2_readdatavalid  out  1  s2 read data valid
s2_waitrequest  out  1  s2 stall
clear_req  in  1  start zero-fill (level, sampled when IDLE)
clear_busy  out  1  zero-fill in progress
clear_done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (reset_n low, async): readdata=0, readdatavalid=0, clear_busy=0, clear_done=0, FSM=IDLE, read pipelines flushed. Memory contents are not reset.
- Lane mapping: R = A_DATA_W/B_DATA_W. An s2 word maps to s1 word s2_address/R, lane group s2_address%R (little-endian; lane group 0 = bits B_DATA_W-1:0).
- Transfer acceptance: a transfer is accepted when read or write is high and waitrequest is low. waitrequest = reset_req | clear_busy. Otherwise zero wait states.
- Write: byte-enabled, committed at the clock edge of acceptance. If read and write are asserted together, the write is performed and no readdatavalid is produced.
- Read: readdata and readdatavalid are presented exactly READ_LATENCY cycles after acceptance. Fully pipelined: one read per cycle per port. readdata holds its last value when valid is low.
- Mixed-port read-during-write to the same word returns OLD data.
- Simultaneous writes from both ports to overlapping bytes: s1 wins on the overlapping bytes; non-overlapping bytes from s2 are still written.
- reset_req high: no new acceptance, in-flight read pipeline stages hold (frozen), clear engine pauses.
- Clear FSM:
  - IDLE: on clear_req -> CLEAR, cnt=0.
  - CLEAR: writes zeros to all bytes of word cnt through the s1 side, one word per unfrozen cycle; clear_busy=1. Advances to DONE when cnt == A_DEPTH-1 is written.
  - DONE: clear_done=1 for one cycle -> IDLE.
  - clear_req during CLEAR/DONE is ignored. Reads accepted before CLEAR entry complete normally with pre-clear data.

Optional Feature:
DIRCC_PROCMEM_COLLISION_EN. When defined: adds outputs collision_flag (sticky, set on any same-cycle overlapping-byte write by both ports, cleared by clear_done or reset) and collision_count (16-bit, saturating at 0xFFFF, reset to 0). When undefined: ports and logic are absent; the arbitration rule is unchanged.

Decomposition:
- Package dircc_procmem_pkg: clear-FSM state enum (IDLE, CLEAR, DONE), a clog2 function, and constant LANE_GROUPS function of the widths.
- Sub-module dircc_procmem_rd_pipe: a READ_LATENCY-deep valid/data pipeline with a freeze input, instantiated once per port.

Test Plan:
- s1 write 0xDEADBEEF to word 5 with be=0xF; s2 reads words 10 and 11 -> 0xBEEF then 0xDEAD, readdatavalid READ_LATENCY cycles after each accept.
- s2 write 0x1234 to address 3 with be=0b01; s1 reads word 1 -> bits 23:16 = 0x34, other bytes unchanged.
- Same cycle: s1 writes 0xAAAAAAAA to word 0 with be=0xF; s2 writes 0x5555 to address 0 -> word 0 = 0xAAAAAAAA (collision_flag=1 when the feature is compiled in).
- s1 reads word 7 while s2 writes it in the same cycle -> s1 returns the old value; a subsequent read returns the new value.
- Pulse clear_req -> clear_busy high for A_DEPTH cycles, waitrequest high on both ports, clear_done pulses once; every word then reads 0.
- Hold reset_req during a READ_LATENCY=2 read -> readdatavalid delayed by the freeze length; assert reset_n low mid-CLEAR -> clear_busy=0 immediately and FSM returns to IDLE.
